fifo_wr_arbiter: RTL and testbench

//  Shares the FIFO write port (W_INC/WR_DATA/FULL) between N_REQ packet sources, one clock domain (write side).

---
 rtl/fifo_arb_pkg.sv | 23 ++
 rtl/fifo_wr_arbiter_rr.sv | 53 +++++
 rtl/fifo_wr_arbiter.sv | 147 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// ----------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared types and default constants for the FIFO write-port arbiter.
//   - arb_state_t : arbiter FSM states (IDLE = re-arbitration, BURST = packet)
//   - DEF_*       : default parameter values for the top level
//   - idx_width() : width of an index into n items (at least 1 bit)
// ----------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_N_REQ      = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PKT_SIZE   = 10;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin arbiter. The requester after i_ptr has top
//   priority, then the next one, wrapping N-1 -> 0.
//   Ports:
//     i_req [N-1:0]     request vector
//     i_ptr [PTR_W-1:0] index of the last winner
//     o_gnt [N-1:0]     one-hot winner, 0 when no request
// ----------------------------------------------------------------------------
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int PTR_W = idx_width(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt
);

    int           w_start;
    logic [N-1:0] w_rot_req;
    logic [N-1:0] w_rot_gnt;
    logic         w_found;

    // Rotate so the highest-priority requester sits at bit 0, pick the lowest
    // set bit, then rotate the one-hot result back into requester order.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        w_start   = (int'(i_ptr) >= N - 1) ? 0 : int'(i_ptr) + 1;
        w_rot_req = '0;
        w_rot_gnt = '0;
        w_found   = 1'b0;
        o_gnt     = '0;

        for (int j = 0; j < N; j++) begin
            w_rot_req[j] = i_req[PTR_W'((w_start + j) % N)];
        end

        for (int j = 0; j < N; j++) begin
            if (!w_found && w_rot_req[j]) begin
                w_rot_gnt[j] = 1'b1;
                w_found      = 1'b1;
            end
        end

        for (int j = 0; j < N; j++) begin
            o_gnt[PTR_W'((w_start + j) % N)] = w_rot_gnt[j];
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares one FIFO write port between N_REQ packet sources. A round-robin
//   winner owns the port for exactly PKT_SIZE accepted beats; writes stall on
//   i_full and packets never interleave. One IDLE cycle separates packets.
//   Ports:
//     i_clk, i_rst     write-domain clock, synchronous active-high reset
//     i_req            per-source "full packet ready", held until done
//     i_req_data       flattened source data, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//     i_full           FIFO full flag (write-domain)
//     o_gnt            one-hot port owner (registered), 0 when idle
//     o_ack            owner's slice written this cycle; source advances
//     o_pkt_done       pulse on the cycle the last beat is written
//     o_pkt_abort      pulse when the owner drops its request mid-packet
//     o_w_inc          FIFO write enable
//     o_wr_data        FIFO write data, 0 when not writing
// ----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PKT_SIZE   = DEF_PKT_SIZE
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_REQ-1:0]            i_req,
    input  logic [N_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic                        i_full,
    output logic [N_REQ-1:0]            o_gnt,
    output logic [N_REQ-1:0]            o_ack,
    output logic                        o_pkt_done,
    output logic                        o_pkt_abort,
    output logic                        o_w_inc,
    output logic [DATA_WIDTH-1:0]       o_wr_data
);

    localparam int CNT_WIDTH = $clog2(PKT_SIZE + 1);
    localparam int PTR_W     = idx_width(N_REQ);

    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(PKT_SIZE - 1);
    localparam logic [PTR_W-1:0]     PTR_RST   = PTR_W'(N_REQ - 1);

    arb_state_t           r_state;
    logic [N_REQ-1:0]     r_gnt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     r_owner;

    arb_state_t           w_state_nxt;
    logic [N_REQ-1:0]     w_gnt_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic [PTR_W-1:0]     w_ptr_nxt;
    logic [PTR_W-1:0]     w_owner_nxt;

    logic [N_REQ-1:0]     w_arb_gnt;
    logic [PTR_W-1:0]     w_arb_idx;
    logic                 w_owner_req;
    logic                 w_burst;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt)
    );

    // Encoded winner index, kept alongside the one-hot grant for the data mux.
    always_comb begin
        w_arb_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_arb_gnt[i]) begin
                w_arb_idx = PTR_W'(i);
            end
        end
    end

    // Write-port outputs. Gated by i_rst so nothing is written or pulsed
    // while reset is asserted, including a reset that lands mid-packet.
    always_comb begin
        w_owner_req = i_req[r_owner];
        w_burst     = (r_state == BURST) && !i_rst;
        o_gnt       = r_gnt;
        o_w_inc     = w_burst && w_owner_req && !i_full;
        o_pkt_abort = w_burst && !w_owner_req;
        o_pkt_done  = o_w_inc && (r_cnt == LAST_BEAT);
        o_ack       = r_gnt & {N_REQ{o_w_inc}};
        o_wr_data   = o_w_inc ? i_req_data[r_owner*DATA_WIDTH +: DATA_WIDTH]
                              : '0;
    end

    // Next-state logic. Both packet completion and abort hand the priority
    // pointer to the owner so the next arbitration starts after it.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;

        case (r_state)
            IDLE: begin
                if (|i_req) begin
                    w_state_nxt = BURST;
                    w_gnt_nxt   = w_arb_gnt;
                    w_owner_nxt = w_arb_idx;
                    w_cnt_nxt   = '0;
                end
            end
            BURST: begin
                if (!w_owner_req || o_pkt_done) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = r_owner;
                end else if (o_w_inc) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state flops use non-blocking assignments so every flop samples
        // the pre-edge values, independent of statement order.
        if (i_rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_ptr   <= PTR_RST;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter (N_REQ=4, DATA_WIDTH=8, PKT_SIZE=10).
//   Sources present word i*32 + beat and advance on their ACK. A FIFO model
//   records every write and is compared against the expected word list.
// ----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int PKT = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic          full = 1'b0;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  gnt;
    logic [N-1:0]  ack;
    logic          pkt_done;
    logic          pkt_abort;
    logic          w_inc;
    logic [DW-1:0] wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    int src_beat [N] = '{default: 0};
    int m_beat   [N] = '{default: 0};

    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q  [$];

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic         full;
        logic [N-1:0] gnt;
        logic         winc;
        logic         done;
        logic         abort;
        logic [DW-1:0] data;
    } vec_t;

    vec_t vecs [20];

    fifo_wr_arbiter #(
        .N_REQ      (N),
        .DATA_WIDTH (DW),
        .PKT_SIZE   (PKT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_req_data  (req_data),
        .i_full      (full),
        .o_gnt       (gnt),
        .o_ack       (ack),
        .o_pkt_done  (pkt_done),
        .o_pkt_abort (pkt_abort),
        .o_w_inc     (w_inc),
        .o_wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    // Packet sources: present the current word, advance on ACK.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst)         src_beat[i] <= 0;
            else if (ack[i]) src_beat[i] <= src_beat[i] + 1;
        end
    end

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = DW'(i*32 + src_beat[i]);
        end
    end

    // FIFO model: capture every write.
    always @(posedge clk) begin
        if (w_inc) fifo_q.push_back(wr_data);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs just after the edge, check outputs at the falling edge.
    task automatic step(input string tag, input logic s_rst, input logic [N-1:0] s_req,
                        input logic s_full, input logic [N-1:0] e_gnt, input logic e_winc,
                        input logic e_done, input logic e_abort, input logic [DW-1:0] e_data);
        @(posedge clk);
        #1;
        rst  = s_rst;
        req  = s_req;
        full = s_full;
        @(negedge clk);
        check({tag, ".gnt"},   32'(gnt),       32'(e_gnt));
        check({tag, ".w_inc"}, 32'(w_inc),     32'(e_winc));
        check({tag, ".ack"},   32'(ack),       32'(e_gnt & {N{e_winc}}));
        check({tag, ".done"},  32'(pkt_done),  32'(e_done));
        check({tag, ".abort"}, 32'(pkt_abort), 32'(e_abort));
        check({tag, ".data"},  32'(wr_data),   32'(e_data));
        if (e_winc) exp_q.push_back(e_data);
    endtask

    task automatic fifo_compare(input string tag);
        int n;
        check({tag, ".fifo_count"}, 32'(fifo_q.size()), 32'(exp_q.size()));
        n = (fifo_q.size() < exp_q.size()) ? fifo_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.fifo[%0d]", tag, i), 32'(fifo_q[i]), 32'(exp_q[i]));
        end
        fifo_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [DW-1:0] word(input int i);
        return DW'(i*32 + m_beat[i]);
    endfunction

    initial begin
        int o;

        // Reset 2 cycles, idle 5, then a single packet from source 0.
        vecs[0] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00};
        for (int i = 2; i <= 6; i++)
            vecs[i] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[7] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00};
        for (int b = 0; b < PKT; b++)
            vecs[8+b] = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, (b == PKT-1), 1'b0, 8'(b)};
        vecs[18] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[19] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00};

        for (int i = 0; i < 20; i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].full,
                 vecs[i].gnt, vecs[i].winc, vecs[i].done, vecs[i].abort, vecs[i].data);
        end
        fifo_compare("t2");

        // All four requesting: order 0,1,2,3,0 with one idle cycle per packet.
        step("t3.rst", 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00);
        step("t3.rst", 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < N; i++) m_beat[i] = 0;
        for (int p = 0; p < 5; p++) begin
            o = p % N;
            step($sformatf("t3.p%0d.idle", p), 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00);
            for (int b = 0; b < PKT; b++) begin
                step($sformatf("t3.p%0d.b%0d", p, b), 1'b0, 4'b1111, 1'b0, 4'(1 << o),
                     1'b1, (b == PKT-1), 1'b0, word(o));
                m_beat[o]++;
            end
        end
        step("t3.end", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00);
        fifo_compare("t3");

        // FULL during beats 4-7 of source 1's packet: grant held, beat 4 resumes.
        step("t4.idle", 1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int b = 0; b < 4; b++) begin
            step($sformatf("t4.b%0d", b), 1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, word(1));
            m_beat[1]++;
        end
        for (int k = 0; k < 4; k++)
            step($sformatf("t4.full%0d", k), 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int b = 4; b < PKT; b++) begin
            step($sformatf("t4.b%0d", b), 1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, (b == PKT-1), 1'b0, word(1));
            m_beat[1]++;
        end
        step("t4.end", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00);
        fifo_compare("t4");

        // Source 2 drops REQ after 3 beats; source 3 wins next.
        step("t5.idle", 1'b0, 4'b1100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int b = 0; b < 3; b++) begin
            step($sformatf("t5.b%0d", b), 1'b0, 4'b1100, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, word(2));
            m_beat[2]++;
        end
        step("t5.abort", 1'b0, 4'b1000, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 8'h00);
        step("t5.rearb", 1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int b = 0; b < PKT; b++) begin
            step($sformatf("t5.r3.b%0d", b), 1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, (b == PKT-1), 1'b0, word(3));
            m_beat[3]++;
        end
        step("t5.end", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00);
        fifo_compare("t5");

        // Reset at beat 5 of source 0's packet: no abort, then req 0 wins again.
        step("t6.idle", 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int b = 0; b < 5; b++) begin
            step($sformatf("t6.b%0d", b), 1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, word(0));
            m_beat[0]++;
        end
        step("t6.rst", 1'b1, 4'b1111, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < N; i++) m_beat[i] = 0;
        step("t6.post", 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int b = 0; b < PKT; b++) begin
            step($sformatf("t6.r0.b%0d", b), 1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, (b == PKT-1), 1'b0, word(0));
            m_beat[0]++;
        end
        step("t6.end", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00);
        fifo_compare("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
